// File: rtl/spi_flash_arbiter.sv
// Shares one SPI configuration-flash port between the JTAG SPI bridge and a fabric SPI master.
// Parks on JTAG when idle; enforces CS-high guard on fabric release, JTAG linger, fabric hold timeout.
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES    = 4,
    parameter int LINGER_CYCLES   = 1024,
    parameter int MAX_HOLD_CYCLES = 65536
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_jtag_csn,
    input  logic       i_jtag_sck,
    input  logic       i_jtag_dq0,
    output logic       o_jtag_dq1,
    input  logic       i_fab_req,
    output logic       o_fab_gnt,
    input  logic       i_fab_csn,
    input  logic       i_fab_sck,
    input  logic       i_fab_dq0,
    output logic       o_fab_dq1,
    output logic       o_flash_csn,
    output logic       o_flash_sck,
    output logic       o_flash_dq0,
    input  logic       i_flash_dq1,
    output logic       o_flash_wpn,
    output logic       o_flash_hldn,
    output logic [1:0] o_owner,
    input  logic       i_clr_status,
    output logic       o_jtag_collision,
    output logic       o_fab_timeout
);

    localparam int GW = $clog2((GUARD_CYCLES    < 2) ? 2 : GUARD_CYCLES)    + 1;
    localparam int LW = $clog2((LINGER_CYCLES   < 2) ? 2 : LINGER_CYCLES)   + 1;
    localparam int HW = $clog2((MAX_HOLD_CYCLES < 2) ? 2 : MAX_HOLD_CYCLES) + 1;
    localparam int CW = (GW > LW) ? ((GW > HW) ? GW : HW) : ((LW > HW) ? LW : HW);

    localparam logic [CW-1:0] C_GUARD_LAST  = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] C_LINGER_LAST = CW'(LINGER_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD_LAST   = CW'(MAX_HOLD_CYCLES - 1);
    localparam logic          C_HOLD_EN     = (MAX_HOLD_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_JTAG   = 3'd1,
        S_LINGER = 3'd2,
        S_FAB    = 3'd3,
        S_GUARD  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_fab_gnt;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_next;
    logic            r_coll;
    logic            r_timeout;
    logic            w_timeout;
    logic            w_coll_set;
    logic            w_csn;

    // Next-state, shared phase counter and owner code for the coming cycle
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = {CW{1'b0}};
        w_timeout    = 1'b0;
        w_owner_next = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_next = S_JTAG;
                end else if (i_fab_req) begin
                    w_next = S_FAB;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_JTAG: begin
                if (r_sync2) begin
                    w_next = S_LINGER;
                end else begin
                    w_next = S_JTAG;
                end
            end
            S_LINGER: begin
                if (!r_sync2) begin
                    w_next = S_JTAG;
                end else if (r_cnt == C_LINGER_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_next     = S_LINGER;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_FAB: begin
                // a timeout in the same cycle as a release still reports the timeout
                if (C_HOLD_EN && (r_cnt == C_HOLD_LAST)) begin
                    w_next    = S_GUARD;
                    w_timeout = 1'b1;
                end else if (!i_fab_req) begin
                    w_next = S_GUARD;
                end else begin
                    w_next     = S_FAB;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_GUARD: begin
                if (r_cnt == C_GUARD_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_next     = S_GUARD;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        case (w_next)
            S_IDLE:   w_owner_next = 2'b00;
            S_JTAG:   w_owner_next = 2'b01;
            S_LINGER: w_owner_next = 2'b01;
            S_FAB:    w_owner_next = 2'b10;
            S_GUARD:  w_owner_next = 2'b11;
            default:  w_owner_next = 2'b00;
        endcase
    end

    assign w_coll_set = ((r_state == S_FAB) || (r_state == S_GUARD)) && !r_sync2;

    // State, counter, csn synchroniser and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_fab_gnt <= 1'b0;
            r_owner   <= 2'b00;
            r_coll    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_sync1   <= i_jtag_csn;
            r_sync2   <= r_sync1;
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_fab_gnt <= (w_next == S_FAB);
            r_owner   <= w_owner_next;
            r_timeout <= w_timeout;
            if (w_coll_set) begin
                r_coll <= 1'b1;
            end else if (i_clr_status) begin
                r_coll <= 1'b0;
            end else begin
                r_coll <= r_coll;
            end
        end
    end

    // Flash pin mux; unrouted MISO returns idle-high
    always_comb begin
        w_csn       = 1'b1;
        o_flash_sck = 1'b0;
        o_flash_dq0 = 1'b0;
        o_jtag_dq1  = 1'b1;
        o_fab_dq1   = 1'b1;
        case (r_state)
            S_IDLE, S_JTAG, S_LINGER: begin
                w_csn       = i_jtag_csn;
                o_flash_sck = i_jtag_sck;
                o_flash_dq0 = i_jtag_dq0;
                o_jtag_dq1  = i_flash_dq1;
            end
            S_FAB: begin
                w_csn       = i_fab_csn;
                o_flash_sck = i_fab_sck;
                o_flash_dq0 = i_fab_dq0;
                o_fab_dq1   = i_flash_dq1;
            end
            S_GUARD: begin
                w_csn = 1'b1;
            end
            default: begin
                w_csn = 1'b1;
            end
        endcase
    end

    assign o_flash_csn      = i_rst ? 1'b1 : w_csn;
    assign o_flash_wpn      = 1'b1;
    assign o_flash_hldn     = 1'b1;
    assign o_fab_gnt        = r_fab_gnt;
    assign o_owner          = r_owner;
    assign o_jtag_collision = r_coll;
    assign o_fab_timeout    = r_timeout;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Randomised and directed bench for spi_flash_arbiter against an owner/countdown reference model.
module tb_spi_flash_arbiter;

    localparam int GRD  = 4;
    localparam int LING = 1024;
    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst, jtag_csn, jtag_sck, jtag_dq0, fab_req, fab_csn, fab_sck, fab_dq0;
    logic       flash_dq1, clr_status;
    logic       w_jtag_dq1, w_fab_gnt, w_fab_dq1, w_flash_csn, w_flash_sck, w_flash_dq0;
    logic       w_flash_wpn, w_flash_hldn, w_coll, w_timeout;
    logic [1:0] w_owner;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who owns the flash and how many cycles remain in the timed phase
    int  m_owner;
    bit  m_linger;
    int  m_left;
    bit  m_coll;
    bit  m_to;
    int  m_hist[$];

    spi_flash_arbiter #(
        .GUARD_CYCLES(GRD), .LINGER_CYCLES(LING), .MAX_HOLD_CYCLES(MAXH)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_jtag_csn(jtag_csn), .i_jtag_sck(jtag_sck), .i_jtag_dq0(jtag_dq0), .o_jtag_dq1(w_jtag_dq1),
        .i_fab_req(fab_req), .o_fab_gnt(w_fab_gnt),
        .i_fab_csn(fab_csn), .i_fab_sck(fab_sck), .i_fab_dq0(fab_dq0), .o_fab_dq1(w_fab_dq1),
        .o_flash_csn(w_flash_csn), .o_flash_sck(w_flash_sck), .o_flash_dq0(w_flash_dq0),
        .i_flash_dq1(flash_dq1), .o_flash_wpn(w_flash_wpn), .o_flash_hldn(w_flash_hldn),
        .o_owner(w_owner), .i_clr_status(clr_status),
        .o_jtag_collision(w_coll), .o_fab_timeout(w_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int s;
        if (rst) begin
            m_owner = 0; m_linger = 0; m_left = 0; m_coll = 0; m_to = 0;
            m_hist.delete(); m_hist.push_back(1); m_hist.push_back(1);
            return;
        end
        s = m_hist.pop_front();
        m_hist.push_back(int'(jtag_csn));
        if ((m_owner == 2 || m_owner == 3) && s == 0) m_coll = 1;
        else if (clr_status) m_coll = 0;
        m_to = 0;
        case (m_owner)
            0: begin
                if (s == 0) begin m_owner = 1; m_linger = 0; end
                else if (fab_req) begin m_owner = 2; m_left = MAXH; end
            end
            1: begin
                if (!m_linger) begin
                    if (s == 1) begin m_linger = 1; m_left = LING; end
                end else if (s == 0) begin
                    m_linger = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_owner = 0;
                end
            end
            2: begin
                if (MAXH != 0) m_left--;
                if (MAXH != 0 && m_left == 0) begin m_to = 1; m_owner = 3; m_left = GRD; end
                else if (!fab_req) begin m_owner = 3; m_left = GRD; end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_owner = 0;
            end
        endcase
    endtask

    task automatic check_cycle();
        logic [4:0] ep;
        case (m_owner)
            0, 1:    ep = {jtag_csn, jtag_sck, jtag_dq0, flash_dq1, 1'b1};
            2:       ep = {fab_csn, fab_sck, fab_dq0, 1'b1, flash_dq1};
            default: ep = 5'b10011;
        endcase
        if (rst) ep[4] = 1'b1;
        chk("pins", {11'd0, w_flash_csn, w_flash_sck, w_flash_dq0, w_jtag_dq1, w_fab_dq1}, {11'd0, ep});
        chk("ctrl", {11'd0, w_fab_gnt, w_owner, w_coll, w_timeout},
            {11'd0, (m_owner == 2), 2'(m_owner), m_coll, m_to});
        chk("wp_hold", {14'd0, w_flash_wpn, w_flash_hldn}, 16'h0003);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
        jtag_sck  = 1'($urandom); jtag_dq0 = 1'($urandom);
        fab_sck   = 1'($urandom); fab_dq0  = 1'($urandom);
        flash_dq1 = 1'($urandom);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt, cnt2, first;
        rst = 1'b1; jtag_csn = 1'b1; jtag_sck = 1'b0; jtag_dq0 = 1'b0;
        fab_req = 1'b0; fab_csn = 1'b1; fab_sck = 1'b0; fab_dq0 = 1'b0;
        flash_dq1 = 1'b0; clr_status = 1'b0;
        m_hist.push_back(1); m_hist.push_back(1);
        m_owner = 0; m_linger = 0; m_left = 0; m_coll = 0; m_to = 0;
        @(negedge clk);
        ticks(3);
        chk("reset_ctrl", {11'd0, w_fab_gnt, w_owner, w_coll, w_timeout}, 16'd0);
        chk("reset_csn", {15'd0, w_flash_csn}, 16'd1);
        rst = 1'b0;
        ticks(2);

        // JTAG scan while parked: pins follow immediately, owner after three edges, then linger
        jtag_csn = 1'b0;
        #1 chk("jtag_follow", {15'd0, w_flash_csn}, 16'd0);
        tick(); tick();
        chk("owner_c2", {14'd0, w_owner}, 16'd0);
        tick();
        chk("owner_c3", {14'd0, w_owner}, 16'd1);
        ticks(47);
        jtag_csn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (w_owner == 2'b01) cnt++;
        end
        chk("linger_len", 16'(cnt), 16'd1026);

        // fabric grant, short transfer, release and guard
        fab_req = 1'b1;
        tick();
        chk("gnt_next", {14'd0, w_fab_gnt, 1'b0}, 16'd2);
        chk("owner_fab", {14'd0, w_owner}, 16'd2);
        fab_csn = 1'b0; ticks(4);
        fab_csn = 1'b1; fab_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (w_owner == 2'b11) cnt++;
        end
        chk("guard_len", 16'(cnt), 16'd4);
        chk("guard_end", {14'd0, w_owner}, 16'd0);

        // hold timeout
        fab_req = 1'b1;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_fab_gnt) cnt++;
            if (w_timeout) cnt2++;
        end
        chk("hold_len", 16'(cnt), 16'd16);
        chk("to_pulses", 16'(cnt2), 16'd1);
        fab_req = 1'b0;
        ticks(3);

        // collision while fabric owns
        fab_req = 1'b1; ticks(2);
        fab_csn = 1'b0; jtag_csn = 1'b0; ticks(3);
        jtag_csn = 1'b1; ticks(3);
        chk("coll_set", {15'd0, w_coll}, 16'd1);
        chk("coll_pins", {15'd0, w_flash_csn}, 16'd0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("coll_clr", {15'd0, w_coll}, 16'd0);
        fab_csn = 1'b1; fab_req = 1'b0; ticks(6);

        // two JTAG scans 200 cycles apart with fab_req high throughout
        jtag_csn = 1'b0; ticks(5);
        fab_req = 1'b1; ticks(15);
        jtag_csn = 1'b1; ticks(200);
        jtag_csn = 1'b0; ticks(20);
        jtag_csn = 1'b1;
        first = -1;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (w_fab_gnt && first < 0) first = i;
        end
        chk("gnt_after_linger", 16'(first), 16'd1028);
        fab_req = 1'b0; ticks(25);

        // reset in the middle of a fabric transfer
        fab_req = 1'b1; ticks(2);
        fab_csn = 1'b0; ticks(3);
        rst = 1'b1;
        #1 chk("rst_csn", {15'd0, w_flash_csn}, 16'd1);
        tick();
        chk("rst_ctrl", {13'd0, w_fab_gnt, w_owner}, 16'd0);
        rst = 1'b0; fab_req = 1'b0; fab_csn = 1'b1;
        ticks(3);

        // randomised traffic, alternating JTAG-busy and JTAG-quiet phases
        for (int c = 0; c < 20000; c++) begin
            if ((c / 3000) % 2 == 0) begin
                if ($urandom_range(0, 99) < 3) jtag_csn = ~jtag_csn;
            end else begin
                jtag_csn = 1'b1;
            end
            if ($urandom_range(0, 99) < 5)   fab_req = ~fab_req;
            if ($urandom_range(0, 99) < 20)  fab_csn = ~fab_csn;
            clr_status = ($urandom_range(0, 99) < 2);
            rst        = ($urandom_range(0, 999) < 1);
            tick();
        end
        rst = 1'b0; clr_status = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
